// File: rtl/pc_fetch_unit.sv
// IF-stage program counter and fetch sequencer.
// Issues valid/ready fetches at the current PC and fills the IF/DOF
// instruction register. Mux redirects beat stalls. A redirect that arrives
// while a fetch is still waiting for memory parks the target and squashes
// that fetch when it completes.
module pc_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               stall,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_1,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    output logic [ADDR_W-1:0]  ir_pc_1
);

    localparam logic [1:0] S_BOOT   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
    localparam logic [1:0] S_SQUASH = 2'd3;

    logic [1:0]         state_q,    state_d;
    logic [ADDR_W-1:0]  pc_q,       pc_d;
    logic [INSTR_W-1:0] ir_q,       ir_d;
    logic               ir_valid_q, ir_valid_d;
    logic [ADDR_W-1:0]  ir_pc_1_q,  ir_pc_1_d;
    logic [ADDR_W-1:0]  tgt_q,      tgt_d;
    logic [INSTR_W-1:0] skid_q,     skid_d;

    // Outputs: the request is live in FETCH and SQUASH; the address is
    // always the registered PC, so it stays stable until the transfer.
    assign pc        = pc_q;
    assign pc_1      = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign imem_req  = (state_q == S_FETCH) || (state_q == S_SQUASH);
    assign imem_addr = pc_q;
    assign ir        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign ir_pc_1   = ir_pc_1_q;

    // Next-state logic; redirect is tested before stall in every state.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        ir_pc_1_d  = ir_pc_1_q;
        tgt_d      = tgt_q;
        skid_d     = skid_q;
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                if (redirect) begin
                    ir_valid_d = 1'b0;
                    if (imem_ready) begin
                        pc_d = redirect_pc;
                    end else begin
                        // Fetch still outstanding: keep the address stable
                        // and discard its data when it arrives.
                        tgt_d   = redirect_pc;
                        state_d = S_SQUASH;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_1;
                    if (!stall) begin
                        ir_d       = imem_rdata;
                        ir_valid_d = 1'b1;
                        ir_pc_1_d  = pc_1;
                    end else begin
                        // ir is frozen by the stall; park the word.
                        skid_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end else if (!stall) begin
                    ir_valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    ir_valid_d = 1'b0;
                    pc_d       = redirect_pc;
                    state_d    = S_FETCH;
                end else if (!stall) begin
                    // pc already advanced past the skid word, so it is
                    // exactly that word's PC+1.
                    ir_d       = skid_q;
                    ir_valid_d = 1'b1;
                    ir_pc_1_d  = pc_q;
                    state_d    = S_FETCH;
                end
            end
            S_SQUASH: begin
                ir_valid_d = 1'b0;
                if (imem_ready) begin
                    pc_d    = redirect ? redirect_pc : tgt_q;
                    state_d = S_FETCH;
                end else if (redirect) begin
                    tgt_d = redirect_pc;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            ir_pc_1_q  <= '0;
            tgt_q      <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            ir_pc_1_q  <= ir_pc_1_d;
            tgt_q      <= tgt_d;
            skid_q     <= skid_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: two instances share inputs, one with
// RESET_PC=0 and one with RESET_PC=16'hFFFE for the wrap case.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, redirect, stall, ready;
    logic [15:0] rpc;

    logic [15:0] pc0, pc10, addr0, irpc0, pc1, pc11, addr1, irpc1;
    logic        req0, irv0, req1, irv1;
    logic [31:0] rd0, ir0, rd1, ir1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Memory model: each word carries a tag plus its own address.
    assign rd0 = {16'hC0DE, addr0};
    assign rd1 = {16'hC0DE, addr1};

    pc_fetch_unit #(.ADDR_W(16), .INSTR_W(32), .RESET_PC(16'h0000)) u0 (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(rpc),
        .stall(stall), .pc(pc0), .pc_1(pc10), .imem_req(req0),
        .imem_addr(addr0), .imem_ready(ready), .imem_rdata(rd0),
        .ir(ir0), .ir_valid(irv0), .ir_pc_1(irpc0));

    pc_fetch_unit #(.ADDR_W(16), .INSTR_W(32), .RESET_PC(16'hFFFE)) u1 (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(rpc),
        .stall(stall), .pc(pc1), .pc_1(pc11), .imem_req(req1),
        .imem_addr(addr1), .imem_ready(ready), .imem_rdata(rd1),
        .ir(ir1), .ir_valid(irv1), .ir_pc_1(irpc1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; stall = 1'b0; ready = 1'b1; rpc = 16'h0;
        step();
        // reset state
        chk("rst_pc0", pc0, 16'h0000);
        chk("rst_pc1", pc1, 16'hFFFE);
        chk("rst_req", req0, 1'b0);
        chk("rst_ir", ir0, 32'h0);
        chk("rst_irv", irv0, 1'b0);
        chk("rst_irpc", irpc0, 16'h0);
        rst = 1'b0;
        // test 1/2: streaming fetch and wrap
        step();
        chk("t1_addr0", addr0, 16'h0000);
        chk("t1_req", req0, 1'b1);
        chk("t1_irv0", irv0, 1'b0);
        chk("t2_addr0", addr1, 16'hFFFE);
        step();
        chk("t1_addr1", addr0, 16'h0001);
        chk("t1_irv1", irv0, 1'b1);
        chk("t1_ir0", ir0, 32'hC0DE0000);
        chk("t1_irpc1", irpc0, 16'h0001);
        chk("t2_addr1", addr1, 16'hFFFF);
        chk("t2_pc1wrap", pc11, 16'h0000);
        chk("t2_irpcFFFF", irpc1, 16'hFFFF);
        step();
        chk("t1_addr2", addr0, 16'h0002);
        chk("t1_irpc2", irpc0, 16'h0002);
        chk("t2_addr2", addr1, 16'h0000);
        chk("t2_irpc0", irpc1, 16'h0000);
        chk("t2_ir", ir1, 32'hC0DEFFFF);
        step();
        chk("t1_addr3", addr0, 16'h0003);
        chk("t1_irpc3", irpc0, 16'h0003);
        step();
        step();
        chk("t3_addr5", addr0, 16'h0005);
        // test 3: redirect while fetch is waiting
        ready = 1'b0; redirect = 1'b1; rpc = 16'h0040;
        step();
        redirect = 1'b0;
        chk("t3_sq_addr", addr0, 16'h0005);
        chk("t3_sq_req", req0, 1'b1);
        chk("t3_sq_irv", irv0, 1'b0);
        step();
        chk("t3_sq_addr2", addr0, 16'h0005);
        chk("t3_sq_irv2", irv0, 1'b0);
        step();
        chk("t3_sq_addr3", addr0, 16'h0005);
        ready = 1'b1;
        step();
        chk("t3_tgt", addr0, 16'h0040);
        chk("t3_irv_drop", irv0, 1'b0);
        step();
        chk("t3_ir40", ir0, 32'hC0DE0040);
        // test 4: stall on a transfer at addr 7
        redirect = 1'b1; rpc = 16'h0006;
        step();
        redirect = 1'b0;
        chk("t4_addr6", addr0, 16'h0006);
        chk("t4_redir_irv", irv0, 1'b0);
        step();
        chk("t4_ir6", ir0, 32'hC0DE0006);
        chk("t4_addr7", addr0, 16'h0007);
        stall = 1'b1;
        step();
        chk("t4_hold_req", req0, 1'b0);
        chk("t4_hold_ir", ir0, 32'hC0DE0006);
        chk("t4_hold_irpc", irpc0, 16'h0007);
        chk("t4_hold_irv", irv0, 1'b1);
        step();
        chk("t4_hold2_req", req0, 1'b0);
        chk("t4_hold2_ir", ir0, 32'hC0DE0006);
        stall = 1'b0;
        step();
        chk("t4_rel_ir", ir0, 32'hC0DE0007);
        chk("t4_rel_irpc", irpc0, 16'h0008);
        chk("t4_rel_addr", addr0, 16'h0008);
        chk("t4_rel_req", req0, 1'b1);
        // test 5: redirect beats stall in HOLD
        stall = 1'b1;
        step();
        chk("t5_hold_req", req0, 1'b0);
        redirect = 1'b1; rpc = 16'h0020;
        step();
        redirect = 1'b0; stall = 1'b0;
        chk("t5_irv", irv0, 1'b0);
        chk("t5_addr", addr0, 16'h0020);
        chk("t5_req", req0, 1'b1);
        step();
        chk("t5_ir20", ir0, 32'hC0DE0020);
        chk("t5_irpc21", irpc0, 16'h0021);
        // test 6: async reset mid-SQUASH
        ready = 1'b0; redirect = 1'b1; rpc = 16'h0099;
        step();
        redirect = 1'b0;
        chk("t6_sq_req", req0, 1'b1);
        chk("t6_sq_addr", addr0, 16'h0021);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_req", req0, 1'b0);
        chk("t6_rst_pc", pc0, 16'h0000);
        chk("t6_rst_irv", irv0, 1'b0);
        rst = 1'b0;
        step();
        chk("t6_fetch_req", req0, 1'b1);
        chk("t6_fetch_addr", addr0, 16'h0000);
        // bubble: no data and no stall clears ir_valid, pc held
        ready = 1'b1;
        step();
        chk("bub_ir0", ir0, 32'hC0DE0000);
        chk("bub_irv1", irv0, 1'b1);
        ready = 1'b0;
        step();
        chk("bub_irv0", irv0, 1'b0);
        chk("bub_addr", addr0, 16'h0001);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
